// File: rtl/awgn_pkg.sv
`default_nettype none
//============================================================================
// awgn_pkg - shared constants, mode encodings and helpers for the AWGN injector
// Rev 1.0
//============================================================================
package awgn_pkg;

  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
  localparam logic [31:0] SEED_STEP = 32'h9E37_79B9;

  typedef enum logic [1:0] {
    MODE_BYPASS = 2'd0,
    MODE_ADD    = 2'd1,
    MODE_NOISE  = 2'd2,
    MODE_RSVD   = 2'd3
  } mode_e;

  // Right-shifting Galois form: feedback taps are applied when bit 0 falls out.
  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return {1'b0, s[31:1]} ^ (s[0] ? LFSR_TAPS : 32'h0);
  endfunction

  function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                 input logic signed [31:0] b,
                                                 input int w);
    logic signed [31:0] sum;
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    sum = a + b;
    hi  = (32'sd1 <<< (w - 1)) - 32'sd1;
    lo  = -(32'sd1 <<< (w - 1));
    if (sum > hi) return hi;
    if (sum < lo) return lo;
    return sum;
  endfunction

endpackage
`default_nettype wire

// File: rtl/awgn_stream_injector_lane_noise_src.sv
`default_nettype none
//============================================================================
// lane_noise_src - per-lane LFSR with centred byte-sum (pseudo-Gaussian) output
// Rev 1.0
//============================================================================
module lane_noise_src
  import awgn_pkg::*;
#(
  parameter logic [31:0] SEED = 32'h0000_0001
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               step,
  output logic signed [10:0] noise
);

  localparam logic [31:0] SEED_EFF = (SEED == 32'h0) ? 32'h1 : SEED;

  logic [31:0] lfsr_q;
  logic [31:0] lfsr_d;
  logic [9:0]  byte_sum;

  // Four uniform bytes summed approximate a bell shape; centring removes the DC.
  always_comb begin
    lfsr_d   = step ? lfsr_next(lfsr_q) : lfsr_q;
    byte_sum = 10'(lfsr_q[7:0]) + 10'(lfsr_q[15:8]) + 10'(lfsr_q[23:16]) + 10'(lfsr_q[31:24]);
    noise    = $signed({1'b0, byte_sum}) - 11'sd510;
  end

  always_ff @(posedge clk) begin
    if (reset) lfsr_q <= SEED_EFF;
    else       lfsr_q <= lfsr_d;
  end

endmodule
`default_nettype wire

// File: rtl/awgn_stream_injector.sv
`default_nettype none
//============================================================================
// awgn_stream_injector - multi-lane AXI-Stream noise injector, 2-stage pipeline
// Rev 1.0
//============================================================================
module awgn_stream_injector
  import awgn_pkg::*;
#(
  parameter int          LANE_W    = 16,
  parameter int          NUM_LANES = 4,
  parameter logic [31:0] SEED_BASE = 32'hACE1_0001
) (
  input  logic                          m00_axis_aclk,
  input  logic                          m00_axis_areset,
  input  logic [LANE_W*NUM_LANES-1:0]   s00_axis_tdata,
  input  logic                          s00_axis_tvalid,
  output logic                          s00_axis_tready,
  input  logic                          s00_axis_tlast,
  output logic [LANE_W*NUM_LANES-1:0]   m00_axis_tdata,
  output logic                          m00_axis_tvalid,
  input  logic                          m00_axis_tready,
  output logic                          m00_axis_tlast,
  input  logic [1:0]                    mode,
  input  logic [4:0]                    scale_shift,
  output logic [31:0]                   frame_count,
  output logic [15:0]                   sat_count
);

  localparam int DW        = LANE_W * NUM_LANES;
  localparam int NOISE_LSH = LANE_W - 11;

  logic clk;
  logic rst;
  logic en;
  logic accept;
  mode_e      eff_mode;
  logic [4:0] eff_shift;
  logic signed [10:0] lane_c [NUM_LANES];
  logic [DW-1:0] noise_vec;
  logic [DW-1:0] result_vec;
  logic [15:0]   sat_lanes;
  logic [16:0]   sat_sum;

  logic          sof_q, sof_d;
  mode_e         act_mode_q, act_mode_d;
  logic [4:0]    act_shift_q, act_shift_d;
  logic          s1_valid_q, s1_valid_d;
  logic          s1_last_q, s1_last_d;
  logic [DW-1:0] s1_data_q, s1_data_d;
  logic [DW-1:0] s1_noise_q, s1_noise_d;
  mode_e         s1_mode_q, s1_mode_d;
  logic          m_valid_q, m_valid_d;
  logic          m_last_q, m_last_d;
  logic [DW-1:0] m_data_q, m_data_d;
  logic [31:0]   frame_cnt_q, frame_cnt_d;
  logic [15:0]   sat_cnt_q, sat_cnt_d;

  assign clk    = m00_axis_aclk;
  assign rst    = m00_axis_areset;
  assign en     = !m_valid_q || m00_axis_tready;
  assign accept = s00_axis_tvalid && en && !rst;
  // First beat of a frame uses the live controls so a same-cycle change is honoured.
  assign eff_mode  = sof_q ? mode_e'(mode) : act_mode_q;
  assign eff_shift = sof_q ? scale_shift : act_shift_q;

  generate
    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
      lane_noise_src #(
        .SEED(SEED_BASE + 32'(k) * SEED_STEP)
      ) u_src (
        .clk  (clk),
        .reset(rst),
        .step (accept),
        .noise(lane_c[k])
      );
    end
  endgenerate

  always_comb begin : p_noise
    logic signed [LANE_W-1:0] c_ext;
    c_ext     = '0;
    noise_vec = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      c_ext = LANE_W'(lane_c[k]) <<< NOISE_LSH;
      if (int'(eff_shift) < LANE_W)
        noise_vec[k*LANE_W +: LANE_W] = c_ext >>> eff_shift;
    end
  end

  always_comb begin : p_result
    logic signed [LANE_W-1:0] x;
    logic signed [LANE_W-1:0] n;
    logic signed [31:0]       a;
    logic signed [31:0]       b;
    logic signed [31:0]       clamped;
    x = '0; n = '0; a = '0; b = '0; clamped = '0;
    result_vec = '0;
    sat_lanes  = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      x = s1_data_q[k*LANE_W +: LANE_W];
      n = s1_noise_q[k*LANE_W +: LANE_W];
      a = (s1_mode_q == MODE_NOISE) ? 32'sd0 : 32'(x);
      b = (s1_mode_q == MODE_ADD || s1_mode_q == MODE_NOISE) ? 32'(n) : 32'sd0;
      clamped = sat_add(a, b, LANE_W);
      result_vec[k*LANE_W +: LANE_W] = clamped[LANE_W-1:0];
      if (clamped != a + b) sat_lanes = sat_lanes + 16'd1;
    end
    sat_sum = {1'b0, sat_cnt_q} + {1'b0, sat_lanes};
  end

  always_comb begin : p_next
    sof_d       = sof_q;
    act_mode_d  = act_mode_q;
    act_shift_d = act_shift_q;
    frame_cnt_d = frame_cnt_q;
    s1_valid_d  = s1_valid_q;
    s1_last_d   = s1_last_q;
    s1_data_d   = s1_data_q;
    s1_noise_d  = s1_noise_q;
    s1_mode_d   = s1_mode_q;
    m_valid_d   = m_valid_q;
    m_last_d    = m_last_q;
    m_data_d    = m_data_q;
    sat_cnt_d   = sat_cnt_q;

    if (accept) begin
      sof_d = s00_axis_tlast;
      if (sof_q) begin
        act_mode_d  = mode_e'(mode);
        act_shift_d = scale_shift;
      end
      if (s00_axis_tlast) frame_cnt_d = frame_cnt_q + 32'd1;
    end

    if (en) begin
      s1_valid_d = accept;
      if (accept) begin
        s1_data_d  = s00_axis_tdata;
        s1_last_d  = s00_axis_tlast;
        s1_noise_d = noise_vec;
        s1_mode_d  = eff_mode;
      end
      m_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        m_data_d  = result_vec;
        m_last_d  = s1_last_q;
        sat_cnt_d = sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sof_q       <= 1'b1;
      act_mode_q  <= MODE_BYPASS;
      act_shift_q <= '0;
      frame_cnt_q <= '0;
      s1_valid_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_data_q   <= '0;
      s1_noise_q  <= '0;
      s1_mode_q   <= MODE_BYPASS;
      m_valid_q   <= 1'b0;
      m_last_q    <= 1'b0;
      m_data_q    <= '0;
      sat_cnt_q   <= '0;
    end else begin
      sof_q       <= sof_d;
      act_mode_q  <= act_mode_d;
      act_shift_q <= act_shift_d;
      frame_cnt_q <= frame_cnt_d;
      s1_valid_q  <= s1_valid_d;
      s1_last_q   <= s1_last_d;
      s1_data_q   <= s1_data_d;
      s1_noise_q  <= s1_noise_d;
      s1_mode_q   <= s1_mode_d;
      m_valid_q   <= m_valid_d;
      m_last_q    <= m_last_d;
      m_data_q    <= m_data_d;
      sat_cnt_q   <= sat_cnt_d;
    end
  end

  assign s00_axis_tready = en && !rst;
  assign m00_axis_tdata  = m_data_q;
  assign m00_axis_tvalid = m_valid_q;
  assign m00_axis_tlast  = m_last_q;
  assign frame_count     = frame_cnt_q;
  assign sat_count       = sat_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_awgn_stream_injector.sv
`default_nettype none
// tb_awgn_stream_injector - scoreboard bench: stimulus pushes expected beats,
// an independent monitor pops and compares on every output handshake.
module tb_awgn_stream_injector;

  localparam logic [31:0] TAPS = 32'h8020_0003;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] s_data = '0;
  logic        s_valid = 1'b0;
  logic        s_last = 1'b0;
  logic        s_ready;
  logic [63:0] m_data;
  logic        m_valid;
  logic        m_last;
  logic        m_ready = 1'b1;
  logic [1:0]  mode_i = 2'd0;
  logic [4:0]  shift_i = 5'd0;
  logic [31:0] frame_count;
  logic [15:0] sat_count;

  awgn_stream_injector dut (
    .m00_axis_aclk  (clk),
    .m00_axis_areset(rst),
    .s00_axis_tdata (s_data),
    .s00_axis_tvalid(s_valid),
    .s00_axis_tready(s_ready),
    .s00_axis_tlast (s_last),
    .m00_axis_tdata (m_data),
    .m00_axis_tvalid(m_valid),
    .m00_axis_tready(m_ready),
    .m00_axis_tlast (m_last),
    .mode           (mode_i),
    .scale_shift    (shift_i),
    .frame_count    (frame_count),
    .sat_count      (sat_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] data;
    logic        last;
  } beat_t;

  beat_t       sb[$];
  int          total = 0;
  int          bad = 0;
  logic [31:0] lfsr [4];
  logic        m_sof;
  logic [1:0]  m_mode;
  logic [4:0]  m_shift;
  int          exp_frames;
  int          exp_sat;
  logic [1:0]  cur_mode = 2'd0;
  logic [4:0]  cur_shift = 5'd0;
  int          stall_left = 0;
  bit          bp_rand = 1'b0;
  bit          held_v = 1'b0;
  beat_t       held;
  beat_t       got;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      lfsr[k] = 32'hACE1_0001 + 32'(k) * 32'h9E37_79B9;
      if (lfsr[k] == 32'h0) lfsr[k] = 32'h1;
    end
    m_sof = 1'b1; m_mode = 2'd0; m_shift = 5'd0;
    exp_frames = 0; exp_sat = 0;
  endtask

  function automatic int noise_of(input logic [31:0] s, input logic [4:0] sh);
    int c;
    c = int'(s[7:0]) + int'(s[15:8]) + int'(s[23:16]) + int'(s[31:24]) - 510;
    if (sh >= 5'd16) return 0;
    return (c * 32) >>> sh;
  endfunction

  function automatic int clamp16(input int v);
    if (v > 32767)  return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  task automatic model_accept(input logic [63:0] d, input logic last);
    beat_t e;
    int x, n, v, r;
    e = '0;
    if (m_sof) begin m_mode = cur_mode; m_shift = cur_shift; end
    for (int k = 0; k < 4; k++) begin
      x = int'($signed(d[k*16 +: 16]));
      n = noise_of(lfsr[k], m_shift);
      case (m_mode)
        2'd1:    v = x + n;
        2'd2:    v = n;
        default: v = x;
      endcase
      r = clamp16(v);
      if (r != v && exp_sat < 65535) exp_sat++;
      e.data[k*16 +: 16] = 16'(r);
      lfsr[k] = {1'b0, lfsr[k][31:1]} ^ (lfsr[k][0] ? TAPS : 32'h0);
    end
    e.last = last;
    sb.push_back(e);
    if (last) exp_frames++;
    m_sof = last;
  endtask

  task automatic drive_ready();
    if (stall_left > 0) begin
      stall_left--;
      m_ready = 1'b0;
    end else begin
      m_ready = bp_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
    drive_ready();
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic send_beat(input logic [63:0] d, input logic last);
    bit done = 1'b0;
    int tries = 0;
    while (!done && tries < 200) begin
      @(posedge clk); #1;
      drive_ready();
      s_valid = 1'b1; s_data = d; s_last = last;
      mode_i = cur_mode; shift_i = cur_shift;
      #1;
      if (s_ready) begin
        model_accept(d, last);
        done = 1'b1;
      end
      tries++;
    end
    chk("accept", 64'(done), 64'd1);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      idle_cycle();
      n++;
    end
    repeat (2) idle_cycle();
    chk("drain", 64'(sb.size()), 64'd0);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_tdata"}, m_data, 64'd0);
    chk({tag, "_tvalid"}, 64'(m_valid), 64'd0);
    chk({tag, "_tlast"}, 64'(m_last), 64'd0);
    chk({tag, "_frame_count"}, 64'(frame_count), 64'd0);
    chk({tag, "_sat_count"}, 64'(sat_count), 64'd0);
    chk({tag, "_tready"}, 64'(s_ready), 64'd0);
  endtask

  function automatic logic [63:0] pack4(input int a, input int b, input int c, input int d);
    return {16'(d), 16'(c), 16'(b), 16'(a)};
  endfunction

  // Monitor: a transfer happens on the next rising edge whenever valid && ready here.
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (rst) begin
        held_v = 1'b0;
      end else begin
        if (held_v) begin
          chk("stall_data", m_data, held.data);
          chk("stall_last", 64'(m_last), 64'(held.last));
          chk("stall_valid", 64'(m_valid), 64'd1);
        end
        if (m_valid && m_ready) begin
          chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
          if (sb.size() != 0) begin
            got = sb.pop_front();
            chk("out_data", m_data, got.data);
            chk("out_last", 64'(m_last), 64'(got.last));
          end
        end
        held_v    = m_valid && !m_ready;
        held.data = m_data;
        held.last = m_last;
      end
    end
  end

  initial begin : stim
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk_outputs_zero("reset");
    rst = 1'b0;
    #1;
    chk("ready_after_reset", 64'(s_ready), 64'd1);

    // Bypass ramp frame with a latency probe on the first beat.
    cur_mode = 2'd0; cur_shift = 5'd0;
    send_beat(pack4(0, 32'hFFFF, 0, 32'h8000), 1'b0);
    idle_cycle();
    chk("latency_s1", 64'(m_valid), 64'd0);
    idle_cycle();
    chk("latency_s2", 64'(m_valid), 64'd1);
    for (int i = 1; i < 1040; i++)
      send_beat(pack4(i, ~i, i * 3, 32'h8000 ^ i), i == 1039);
    drain();
    chk("frame_count_bypass", 64'(frame_count), 64'd1);

    // Reserved mode behaves as bypass.
    cur_mode = 2'd3;
    for (int i = 0; i < 4; i++) send_beat(pack4(i * 7, -i, 12345, -32768), i == 3);
    drain();

    // Noise only, full scale then fully attenuated.
    cur_mode = 2'd2; cur_shift = 5'd0;
    for (int i = 0; i < 10; i++) send_beat(pack4(100, 200, 300, 400), i == 9);
    cur_shift = 5'd16;
    for (int i = 0; i < 4; i++) send_beat(pack4(1, 2, 3, 4), i == 3);
    drain();

    // Saturation at both rails.
    cur_mode = 2'd1; cur_shift = 5'd0;
    for (int i = 0; i < 8; i++) send_beat(pack4(32'h7FF0, 32'h7FF0, 32'h7FF0, 32'h7FF0), 1'b0);
    for (int i = 0; i < 4; i++) send_beat(pack4(32'h8000, 32'h8005, 32'h8000, 32'h8010), i == 3);
    drain();
    chk("sat_count", 64'(sat_count), 64'(exp_sat));
    chk("sat_seen", 64'(exp_sat > 0), 64'd1);

    // Backpressure: fixed stall mid-frame, then random downstream ready.
    cur_mode = 2'd1; cur_shift = 5'd3;
    for (int i = 0; i < 40; i++) begin
      if (i == 10) stall_left = 5;
      if (i == 20) bp_rand = 1'b1;
      send_beat(pack4(i * 311, -i * 97, i, 32'h4000 - i), i == 39);
    end
    drain();
    bp_rand = 1'b0;

    // Per-frame control latching, then a single-beat frame with same-cycle control.
    cur_mode = 2'd1; cur_shift = 5'd2;
    for (int i = 0; i < 20; i++) begin
      if (i == 10) begin cur_shift = 5'd6; cur_mode = 2'd2; end
      send_beat(pack4(i * 100, i * 50, -i * 25, 1000), i == 19);
    end
    for (int i = 0; i < 5; i++) send_beat(pack4(i, i, i, i), i == 4);
    cur_mode = 2'd2; cur_shift = 5'd4;
    send_beat(pack4(9, 9, 9, 9), 1'b1);
    drain();
    chk("frame_count_total", 64'(frame_count), 64'(exp_frames));

    // Reset mid-frame, then the post-reset noise sequence must restart from the seeds.
    cur_mode = 2'd2; cur_shift = 5'd0;
    for (int i = 0; i < 12; i++) send_beat(pack4(i, i, i, i), 1'b0);
    @(posedge clk); #1;
    rst = 1'b1; s_valid = 1'b0; m_ready = 1'b1;
    @(posedge clk); #1;
    chk_outputs_zero("midreset");
    sb.delete();
    model_reset();
    rst = 1'b0;
    #1;
    chk("ready_after_midreset", 64'(s_ready), 64'd1);
    for (int i = 0; i < 10; i++) send_beat(pack4(0, 0, 0, 0), i == 9);
    drain();
    chk("frame_count_after_reset", 64'(frame_count), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/awgn_stream_injector.md
# awgn_stream_injector

Parametrised successor to the channel-sounder `noise_generator`. It adds pseudo-Gaussian noise, lane by lane, to a multi-lane AXI-Stream sample bus, with:
- selectable mode and per-frame latched scaling;
- saturating arithmetic and saturation telemetry;
- full backpressure support.

It sits between the probe-sequence source and the DMA/DAC path and emulates a noisy channel for loopback sounding.

## Interface
- LANE_W, 16, signed sample width per lane
- NUM_LANES, 4, lanes packed LSB-first in tdata
- SEED_BASE, 32'hACE1_0001, lane-0 LFSR seed
- m00_axis_aclk  in  1  sole clock
- m00_axis_areset  in  1  reset, synchronous, active-high
- s00_axis_tdata  in  LANE_W*NUM_LANES  input samples
- s00_axis_tvalid  in  1  input beat valid
- s00_axis_tready  out  1  input accept
- s00_axis_tlast  in  1  end of frame
- m00_axis_tdata  out  LANE_W*NUM_LANES  output samples
- m00_axis_tvalid  out  1  output beat valid
- m00_axis_tready  in  1  downstream accept
- m00_axis_tlast  out  1  end of frame, aligned with data
- mode  in  2  0 bypass, 1 add noise, 2 noise only, 3 treated as bypass
- scale_shift  in  5  noise attenuation, arithmetic right shift count
- frame_count  out  32  accepted input tlast beats
- sat_count  out  16  saturated lane results, sticky at 16'hFFFF

## Operation
- **Beat acceptance:** a beat is accepted when s00_axis_tvalid && s00_axis_tready.
  - Per lane, a 32-bit Galois LFSR (taps 32'h8020_0003) advances exactly one step per accepted beat, and only then.
- **Seeds:** lane k seed = SEED_BASE + k*32'h9E37_79B9; a zero seed is replaced by 32'h1.
- **Noise generation (per lane, per beat):**
  - u = sum of the four unsigned bytes of the current LFSR state (0..1020).
  - c = u − 510, a signed 11-bit value in [−510, 510].
  - n = (c <<< (LANE_W−11)) >>> active_shift.
  - active_shift ≥ LANE_W forces n = 0.
- **Result per lane:**
  - bypass: x
  - add: sat(x + n)
  - noise only: sat(n)
  - sat clamps to [−2^(LANE_W−1), 2^(LANE_W−1)−1].
- **Saturation telemetry:** each clamped lane increments sat_count by 1. Multiple lanes on the same beat add their count; the counter saturates at 16'hFFFF.
- **Control latching:**
  - active_mode and active_shift are sampled from mode and scale_shift on the first accepted beat of each frame.
  - The first beat of a frame is the first beat after reset or after an accepted tlast.
  - Changes mid-frame have no effect until the next frame.
- **Framing:** tlast propagates unchanged with its beat. frame_count increments on each accepted input tlast and wraps at 2^32.
- **Reset:**
  - All valid flags are cleared and in-flight beats are dropped.
  - LFSRs are reseeded and the start-of-frame flag is set.
  - active_mode resets to 0 and active_shift to 0.
  - Output reset values: m00_axis_tdata 0, m00_axis_tvalid 0, m00_axis_tlast 0, frame_count 0, sat_count 0, s00_axis_tready 0 while reset is asserted.

## Timing
- Two-stage pipeline:
  - S1 registers the sample, tlast and noise.
  - S2 registers the saturated result.
- **Latency:** 2 cycles from input acceptance to m00_axis_tvalid, with no stall.
- **Enable and ready:**
  - Pipeline enable en = !m00_axis_tvalid || m00_axis_tready.
  - s00_axis_tready = en, registered-free, high in the first cycle after reset deasserts.
  - Throughput is 1 beat per cycle sustained.
- **Stall behaviour:** while m00_axis_tvalid && !m00_axis_tready, all output signals hold stable and the LFSRs hold. No beat is lost or duplicated.
- **Bubbles:** S1 and S2 valid flags carry bubbles through; input valid gaps never advance the LFSR.
- **Boundary cases:**
  - A single-beat frame (tvalid with tlast on the first beat) both latches control and increments frame_count.
  - A control change in the same cycle as the first beat is used.
- **Reset priority:** reset during a stall overrides hold.

## Structure
- Package awgn_pkg contains:
  - LFSR_TAPS
  - SEED_STEP (32'h9E37_79B9)
  - mode encodings
  - the sat_add function (signed add, clamp to LANE_W)
- Sub-module lane_noise_src, instantiated NUM_LANES times:
  - holds the LFSR, seed logic and byte-sum/centre.
  - ports: clk, reset, step, 11-bit signed noise out.
- The top level holds the control latch, the pipeline, the counters and the handshake.

## Test plan
- **Bypass:** mode 0, ramp 0..1039 on lane 0, tlast every 1040 beats, tready=1 → output equals input exactly, 2-cycle latency, frame_count=1 after the first frame.
- **Noise only:** mode 2, scale_shift 0, ten beats → each lane equals a bit-accurate byte-sum model from its seed (lane 0 seed 32'hACE1_0001). All values lie within [−16320, 16320]. scale_shift 16 → all zero.
- **Saturation:** mode 1, scale_shift 0, lane input 16'h7FF0 and lane noise positive → output 16'h7FFF, sat_count increments by the number of clamped lanes.
- **Backpressure:** m00_axis_tready low 5 cycles mid-frame, then pseudo-random 50% → output sequence identical to the tready=1 run. Data is stable during stalls and the noise sequence is unchanged.
- **Per-frame latching:** change scale_shift 2→6 at beat 500 of a frame → the new shift appears only from the first beat after the tlast.
- **Reset mid-frame:** assert reset at beat 300 → the following cycle all outputs are 0. The next frame reproduces the post-reset noise sequence of the first frame.
